// File: rtl/counter_pkg.sv
// Shared constants and helpers for the modulo-N up/down counter family.
package counter_pkg;

   localparam logic CNT_UP = 1'b1;
   localparam logic CNT_DN = 1'b0;

   // Loads at or beyond the modulus land on the top legal value.
   function automatic int unsigned clamp_load(input int unsigned val,
                                              input int unsigned modulus);
      return (val < modulus) ? val : modulus - 1;
   endfunction

endpackage

// File: rtl/count_term_detect.sv
// Terminal-count detection: at_term is the raw end-of-range condition for the
// current direction, tc is the same condition gated by the count enable.
module count_term_detect
   import counter_pkg::*;
#(
   parameter int          WIDTH   = 4,
   parameter int unsigned MODULUS = 16
) (
   input  logic [WIDTH-1:0] count,
   input  logic             up_dn,
   input  logic             en,
   output logic             tc,
   output logic             at_term
);

   localparam logic [WIDTH:0] LAST_W = (WIDTH+1)'(MODULUS - 1);

   logic [WIDTH:0] count_ext;

   assign count_ext = {1'b0, count};
   assign at_term   = (up_dn == CNT_UP) ? (count_ext == LAST_W) : (count_ext == '0);
   assign tc        = en & at_term;

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo-N up/down counter with load clamp, terminal count and wrap pulse.
// Define MOD_UPDOWN_COUNTER_SAT_EN to saturate at the range ends instead of wrapping.
module mod_updown_counter
   import counter_pkg::*;
#(
   parameter int          WIDTH   = 4,
   parameter int unsigned MODULUS = 16,
   parameter int unsigned INIT    = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrapped
);

   if (WIDTH < 1 || WIDTH > 31) begin : g_bad_width
      $error("mod_updown_counter: WIDTH %0d outside 1..31", WIDTH);
   end
   if (MODULUS < 2 || 64'(MODULUS) > (64'd1 << WIDTH)) begin : g_bad_modulus
      $error("mod_updown_counter: MODULUS %0d outside 2..2**WIDTH", MODULUS);
   end
   if (INIT >= MODULUS) begin : g_bad_init
      $error("mod_updown_counter: INIT %0d not below MODULUS %0d", INIT, MODULUS);
   end

   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH:0]   step_w;
   logic             at_term;

   count_term_detect #(
      .WIDTH   (WIDTH),
      .MODULUS (MODULUS)
   ) u_term (
      .count   (count_q),
      .up_dn   (up_dn),
      .en      (en),
      .tc      (tc),
      .at_term (at_term)
   );

   // One extra bit keeps the step free of 2**WIDTH overflow; the range-end
   // cases are handled by at_term before the step result is ever used.
   assign step_w = (up_dn == CNT_UP) ? ({1'b0, count_q} + (WIDTH+1)'(1))
                                     : ({1'b0, count_q} - (WIDTH+1)'(1));

`ifdef MOD_UPDOWN_COUNTER_SAT_EN

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = WIDTH'(clamp_load(32'(load_val), MODULUS));
      end else if (en && !at_term) begin
         count_d = WIDTH'(step_w);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= WIDTH'(INIT);
      end else begin
         count_q <= count_d;
      end
   end

   assign wrapped = 1'b0;

`else

   localparam logic [WIDTH:0] LAST_W = (WIDTH+1)'(MODULUS - 1);

   logic wrapped_q, wrapped_d;

   always_comb begin
      count_d   = count_q;
      wrapped_d = 1'b0;
      if (load) begin
         count_d = WIDTH'(clamp_load(32'(load_val), MODULUS));
      end else if (en) begin
         if (at_term) begin
            count_d   = (up_dn == CNT_UP) ? '0 : WIDTH'(LAST_W);
            wrapped_d = 1'b1;
         end else begin
            count_d = WIDTH'(step_w);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q   <= WIDTH'(INIT);
         wrapped_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         wrapped_q <= wrapped_d;
      end
   end

   assign wrapped = wrapped_q;

`endif

   assign count = count_q;

endmodule
